// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
//   DIV_WIDTH : default operand width
//   DIV_ITERS : restoring steps per divide (one quotient bit each)
//   DIV_CNT_W : width of the iteration counter
//   div_state_e : controller state encoding
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ON   = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration, purely combinational.
// Ports:
//   i_rem      : partial remainder before the step
//   i_dvd      : dividend shift register (quotient bits fill from the LSB)
//   i_dvs      : divisor magnitude
//   o_rem      : partial remainder after the step
//   o_dvd      : dividend/quotient register after the step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_dvd,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_dvd
);

  logic [W:0] w_shifted;
  logic [W:0] w_trial;
  logic       w_qbit;

  // The shifted remainder can need W+1 bits; the trial result always fits
  // back into W bits when it is non-negative because it is below the divisor.
  assign w_shifted = {i_rem, i_dvd[W-1]};
  assign w_trial   = w_shifted - {1'b0, i_dvs};
  assign w_qbit    = ~w_trial[W];

  assign o_rem = w_qbit ? w_trial[W-1:0] : w_shifted[W-1:0];
  assign o_dvd = {i_dvd[W-2:0], w_qbit};

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for the execute stage.
// Ports:
//   clk, rst    : core clock, synchronous active-high reset
//   start       : divide request level, held while the DIV/DIVU is in EX
//   signed_div  : 1 = signed DIV, 0 = DIVU
//   opdata1/2   : dividend / divisor
//   annul       : kills the in-flight divide
//   result      : {remainder, quotient}, held until the next completion
//   ready       : result valid (one cycle)
//   stall       : pipeline hold request
//
// state  | meaning
// S_IDLE | waiting for start
// S_ON   | iterating, one quotient bit per clock
// S_DONE | result valid for one cycle
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_e r_state, w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic               r_q_neg;
  logic               r_r_neg;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_dvd_nxt;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_div0;

  // Most-negative operand wraps back to itself under negation; the
  // unsigned magnitude 2^(WIDTH-1) is still correct for the iteration.
  assign w_abs1 = (signed_div & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign w_abs2 = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  assign w_div0 = (opdata2 == '0);

  div_step #(.W(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_dvd (w_dvd_nxt)
  );

  assign w_q_fix = r_q_neg ? -w_dvd_nxt : w_dvd_nxt;
  assign w_r_fix = r_r_neg ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (annul) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = w_div0 ? S_DONE : S_ON;
        S_ON:    if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (r_state == S_DONE);
    stall = start & ~ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
    end else if (!annul) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_div0) begin
              r_result <= '0;
            end else begin
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_q_neg <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              r_r_neg <= signed_div & opdata1[WIDTH-1];
            end
          end
        end
        S_ON: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dvd_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_result <= {w_r_fix, w_q_fix};
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
